// File: rtl/memory_protocol_pkg.sv
// Shared block-transfer protocol definitions used by the L1 cache and the memory responder.
package memory_protocol_pkg;

    localparam int unsigned BW_COMMAND_ENCODING = 3;

    typedef enum logic [BW_COMMAND_ENCODING-1:0] {
        CMD_NOP       = 3'd0,
        CMD_FETCH     = 3'd1,
        CMD_WRITEBACK = 3'd2,
        CMD_FILL      = 3'd3
    } cache_command_e;

    // Ceiling log2 usable in constant expressions; CLOG2(1) is 0.
    function automatic int unsigned CLOG2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((33'(1) << i) < 33'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/memory_request_fifo.sv
// In-order request buffer with registered occupancy and a first-word-fall-through head.
module memory_request_fifo
    import memory_protocol_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? CLOG2(DEPTH) : 1;
    localparam int unsigned CNT_W = CLOG2(DEPTH + 1);

    logic [WIDTH-1:0] entries [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = entries[rd_ptr];

    // Payload storage; contents need no reset because occupancy gates every read.
    always_ff @(posedge clock_i) begin
        if (push_ok) begin
            entries[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; push and pop may coincide.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

endmodule

// File: rtl/external_memory_responder.sv
// Next-level memory model: buffers cache requests, applies writebacks, answers fetches with fills.
module external_memory_responder
    import memory_protocol_pkg::*;
#(
    parameter int unsigned BW_USED_ADDR_WORD     = 24,
    parameter int unsigned BW_DATA_EXTERNAL_BUS  = 512,
    parameter int unsigned BW_CACHE_COMMAND      = 3,
    parameter int unsigned CACHE_WORDS_PER_BLOCK = 16,
    parameter int unsigned MEMORY_BLOCKS         = 1024,
    parameter int unsigned READ_LATENCY          = 4,
    parameter int unsigned FIFO_DEPTH            = 2
) (
    input  logic                            clock_i,
    input  logic                            reset_i,
    input  logic                            write_i,
    input  logic [BW_CACHE_COMMAND-1:0]     command_i,
    input  logic [BW_USED_ADDR_WORD-1:0]    addr_i,
    input  logic [BW_DATA_EXTERNAL_BUS-1:0] data_i,
    output logic                            full_o,
    output logic                            write_o,
    output logic [BW_CACHE_COMMAND-1:0]     command_o,
    output logic [BW_USED_ADDR_WORD-1:0]    addr_o,
    output logic [BW_DATA_EXTERNAL_BUS-1:0] data_o,
    input  logic                            full_i,
    output logic                            error_o
);

    localparam int unsigned BW_WORDS_PER_BLOCK = CLOG2(CACHE_WORDS_PER_BLOCK);
    localparam int unsigned BW_LINE_INDEX      = CLOG2(MEMORY_BLOCKS);
    localparam int unsigned BW_COUNTER         = CLOG2(READ_LATENCY + 1);
    localparam logic [BW_USED_ADDR_WORD-1:0] LINE_MASK =
        ~BW_USED_ADDR_WORD'(CACHE_WORDS_PER_BLOCK - 1);

    typedef struct packed {
        logic [BW_CACHE_COMMAND-1:0]     command;
        logic [BW_USED_ADDR_WORD-1:0]    addr;
        logic [BW_DATA_EXTERNAL_BUS-1:0] data;
    } request_t;

    localparam int unsigned REQUEST_W = $bits(request_t);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_SEND
    } state_e;

    state_e                          state;
    request_t                        push_request;
    request_t                        head;
    logic                            fifo_empty;
    logic                            pop;
    logic                            ram_write;
    logic [BW_LINE_INDEX-1:0]        head_line;
    logic [BW_LINE_INDEX-1:0]        fetch_line;
    logic [BW_USED_ADDR_WORD-1:0]    fetch_addr;
    logic [BW_COUNTER-1:0]           counter;
    logic [BW_DATA_EXTERNAL_BUS-1:0] ram [MEMORY_BLOCKS];

    assign push_request = '{command: command_i, addr: addr_i, data: data_i};
    assign pop          = (state == ST_IDLE) && !fifo_empty;
    assign ram_write    = pop && (head.command == BW_CACHE_COMMAND'(CMD_WRITEBACK));
    assign head_line    = head.addr[BW_WORDS_PER_BLOCK +: BW_LINE_INDEX];
    assign fetch_line   = fetch_addr[BW_WORDS_PER_BLOCK +: BW_LINE_INDEX];
    assign write_o      = (state == ST_SEND) && !full_i;

    memory_request_fifo #(
        .WIDTH (REQUEST_W),
        .DEPTH (FIFO_DEPTH)
    ) u_request_fifo (
        .clock_i   (clock_i),
        .reset_i   (reset_i),
        .push      (write_i),
        .push_data (push_request),
        .pop       (pop),
        .head      (head),
        .full      (full_o),
        .empty     (fifo_empty)
    );

    // Backing RAM write port; contents survive reset.
    always_ff @(posedge clock_i) begin
        if (ram_write) begin
            ram[head_line] <= head.data;
        end
    end

    // Request sequencer: decode the FIFO head, time the read latency, hold the fill until accepted.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state      <= ST_IDLE;
            counter    <= '0;
            fetch_addr <= '0;
            command_o  <= '0;
            addr_o     <= '0;
            data_o     <= '0;
            error_o    <= 1'b0;
        end else begin
            if (write_i && full_o) begin
                error_o <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        case (head.command)
                            BW_CACHE_COMMAND'(CMD_FETCH): begin
                                fetch_addr <= head.addr & LINE_MASK;
                                counter    <= BW_COUNTER'(READ_LATENCY);
                                state      <= ST_WAIT;
                            end
                            BW_CACHE_COMMAND'(CMD_WRITEBACK),
                            BW_CACHE_COMMAND'(CMD_NOP),
                            BW_CACHE_COMMAND'(CMD_FILL): begin
                                state <= ST_IDLE;
                            end
                            default: begin
                                error_o <= 1'b1;
                            end
                        endcase
                    end
                end
                ST_WAIT: begin
                    if (counter == BW_COUNTER'(1)) begin
                        data_o    <= ram[fetch_line];
                        addr_o    <= fetch_addr;
                        command_o <= BW_CACHE_COMMAND'(CMD_FILL);
                        state     <= ST_SEND;
                    end else begin
                        counter <= counter - BW_COUNTER'(1);
                    end
                end
                ST_SEND: begin
                    if (!full_i) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_external_memory_responder.sv
// Directed bench for external_memory_responder with default parameters.
module tb_external_memory_responder;

    logic         clock_i;
    logic         reset_i;
    logic         write_i;
    logic [2:0]   command_i;
    logic [23:0]  addr_i;
    logic [511:0] data_i;
    logic         full_o;
    logic         write_o;
    logic [2:0]   command_o;
    logic [23:0]  addr_o;
    logic [511:0] data_o;
    logic         full_i;
    logic         error_o;

    int checks;
    int failures;
    int n;
    int fills;

    localparam logic [511:0] LINE_12 = {32{16'h1212}};
    localparam logic [511:0] LINE_01 = {16{32'h0101_F00D}};
    localparam logic [511:0] LINE_A5 = {64{8'hA5}};
    localparam logic [511:0] LINE_20 = {8{64'hDEAD_BEEF_0000_0200}};

    external_memory_responder dut (
        .clock_i   (clock_i),
        .reset_i   (reset_i),
        .write_i   (write_i),
        .command_i (command_i),
        .addr_i    (addr_i),
        .data_i    (data_i),
        .full_o    (full_o),
        .write_o   (write_o),
        .command_o (command_o),
        .addr_o    (addr_o),
        .data_o    (data_o),
        .full_i    (full_i),
        .error_o   (error_o)
    );

    initial clock_i = 1'b0;
    always #5 clock_i = ~clock_i;

    task automatic step();
        @(posedge clock_i);
        #1;
    endtask

    task automatic check_bit(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    task automatic check_val(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic check_line(input string tag, input logic [511:0] observed, input logic [511:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive one request for one cycle; returns in the cycle after the push edge.
    task automatic push(input logic [2:0] cmd, input logic [23:0] addr, input logic [511:0] data);
        command_i = cmd;
        addr_i    = addr;
        data_i    = data;
        write_i   = 1'b1;
        step();
        write_i   = 1'b0;
        command_i = 3'd0;
        addr_i    = '0;
        data_i    = '0;
    endtask

    // Count cycles from the push edge (cycle 1) until write_o is seen, bounded.
    task automatic wait_fill(output int cycles);
        cycles = 1;
        while (write_o !== 1'b1 && cycles < 60) begin
            step();
            cycles++;
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset_i   = 1'b1;
        write_i   = 1'b0;
        command_i = 3'd0;
        addr_i    = '0;
        data_i    = '0;
        full_i    = 1'b0;
        step();
        step();

        // Reset values
        check_bit("rst_full_o", full_o, 1'b0);
        check_bit("rst_write_o", write_o, 1'b0);
        check_val("rst_command_o", 32'(command_o), 32'h0);
        check_val("rst_addr_o", 32'(addr_o), 32'h0);
        check_line("rst_data_o", data_o, '0);
        check_bit("rst_error_o", error_o, 1'b0);
        reset_i = 1'b0;
        step();

        // Preload lines 0x12 and 0x01, then reset again; RAM must keep them
        push(3'd2, 24'h000120, LINE_12);
        push(3'd2, 24'h000010, LINE_01);
        step();
        step();
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
        step();

        // Fetch after reset
        push(3'd1, 24'h000123, '0);
        wait_fill(n);
        check_val("fetch_latency", 32'(n), 32'd6);
        check_val("fetch_addr", 32'(addr_o), 32'h000120);
        check_val("fetch_cmd", 32'(command_o), 32'd3);
        check_line("fetch_data", data_o, LINE_12);
        step();
        check_bit("fetch_done_write_o", write_o, 1'b0);

        // Writeback then fetch to the same line
        push(3'd2, 24'h000040, LINE_A5);
        push(3'd1, 24'h000047, '0);
        wait_fill(n);
        check_val("wbf_latency", 32'(n), 32'd6);
        check_val("wbf_addr", 32'(addr_o), 32'h000040);
        check_line("wbf_data", data_o, LINE_A5);
        step();

        // Backpressure: hold full_i for 10 cycles of SEND
        full_i = 1'b1;
        push(3'd1, 24'h000045, '0);
        repeat (5) step();
        for (int i = 0; i < 10; i++) begin
            check_bit("bp_write_o_low", write_o, 1'b0);
            check_val("bp_addr_stable", 32'(addr_o), 32'h000040);
            check_line("bp_data_stable", data_o, LINE_A5);
            step();
        end
        full_i = 1'b0;
        #1;
        check_bit("bp_write_o_release", write_o, 1'b1);
        check_val("bp_cmd", 32'(command_o), 32'd3);
        step();
        check_bit("bp_write_o_after", write_o, 1'b0);

        // Overflow: FSM parked in SEND, three pushes, third dropped
        full_i = 1'b1;
        push(3'd1, 24'h000123, '0);
        repeat (5) step();
        check_bit("ovf_send_write_o", write_o, 1'b0);
        check_bit("ovf_full_before_1", full_o, 1'b0);
        push(3'd2, 24'h000200, LINE_20);
        check_bit("ovf_full_before_2", full_o, 1'b0);
        push(3'd1, 24'h000205, '0);
        check_bit("ovf_full_before_3", full_o, 1'b1);
        check_bit("ovf_error_before", error_o, 1'b0);
        push(3'd1, 24'h000123, '0);
        check_bit("ovf_error_set", error_o, 1'b1);
        full_i = 1'b0;
        #1;
        fills = 0;
        for (int c = 0; c < 40; c++) begin
            if (write_o === 1'b1) begin
                fills++;
                if (fills == 1) begin
                    check_val("ovf_fill1_addr", 32'(addr_o), 32'h000120);
                    check_line("ovf_fill1_data", data_o, LINE_12);
                end else if (fills == 2) begin
                    check_val("ovf_fill2_addr", 32'(addr_o), 32'h000200);
                    check_line("ovf_fill2_data", data_o, LINE_20);
                end
            end
            step();
        end
        check_val("ovf_fill_count", 32'(fills), 32'd2);
        check_bit("ovf_error_sticky", error_o, 1'b1);

        // Reset clears the sticky error
        reset_i = 1'b1;
        #1;
        check_bit("rst_clears_error", error_o, 1'b0);
        step();
        reset_i = 1'b0;
        step();

        // Address wrap: line 0x401 aliases line 1
        push(3'd1, 24'h004010, '0);
        wait_fill(n);
        check_val("wrap_latency", 32'(n), 32'd6);
        check_val("wrap_addr", 32'(addr_o), 32'h004010);
        check_line("wrap_data", data_o, LINE_01);
        step();

        // Unknown command: no fill, sticky error
        push(3'd7, 24'h000000, '0);
        fills = 0;
        for (int c = 0; c < 12; c++) begin
            if (write_o === 1'b1) fills++;
            step();
        end
        check_val("unk_no_fill", 32'(fills), 32'd0);
        check_bit("unk_error", error_o, 1'b1);

        // Asynchronous reset while in WAIT
        push(3'd1, 24'h000047, '0);
        step();
        step();
        #2;
        reset_i = 1'b1;
        #1;
        check_bit("arst_error_o", error_o, 1'b0);
        check_bit("arst_write_o", write_o, 1'b0);
        check_bit("arst_full_o", full_o, 1'b0);
        check_val("arst_command_o", 32'(command_o), 32'h0);
        check_val("arst_addr_o", 32'(addr_o), 32'h0);
        check_line("arst_data_o", data_o, '0);
        step();
        reset_i = 1'b0;
        fills = 0;
        for (int c = 0; c < 15; c++) begin
            if (write_o === 1'b1) fills++;
            step();
        end
        check_val("arst_no_fill", 32'(fills), 32'd0);
        push(3'd1, 24'h000047, '0);
        wait_fill(n);
        check_val("arst_refetch_latency", 32'(n), 32'd6);
        check_val("arst_refetch_addr", 32'(addr_o), 32'h000040);
        check_line("arst_refetch_data", data_o, LINE_A5);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
